// File: rtl/multicycle_cpu_control.sv
// Multi-cycle RV32I control unit. It steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB, stalls while MIO_ready is low, and traps on
// illegal opcodes or on an optional memory wait timeout.
module multicycle_cpu_control #(
    parameter int unsigned TIMEOUT_CYCLES = 0,
    parameter int unsigned CNT_W          = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] OPcode,
    input  logic [2:0] Fun3,
    input  logic       Fun7,
    input  logic       MIO_ready,
    output logic [2:0] ImmSel,
    output logic       ALUSrc_B,
    output logic [1:0] MemtoReg,
    output logic [3:0] ALU_Control,
    output logic       Jump,
    output logic       Branch,
    output logic       RegWrite,
    output logic       MemRW,
    output logic       CPU_MIO,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic [2:0] state,
    output logic       trap,
    output logic       bus_timeout
);

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_TRAP   = 3'd7;

    localparam logic [4:0] OP_R      = 5'b01100;
    localparam logic [4:0] OP_I      = 5'b00100;
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;

    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             trap_q, trap_d;
    logic             bto_q, bto_d;

    logic is_load, is_store, is_branch, is_jump, is_legal;
    logic wait_c;

    assign is_load   = (OPcode == OP_LOAD);
    assign is_store  = (OPcode == OP_STORE);
    assign is_branch = (OPcode == OP_BRANCH);
    assign is_jump   = (OPcode == OP_JAL) || (OPcode == OP_JALR);
    assign is_legal  = (OPcode == OP_R) || (OPcode == OP_I) || is_load || is_store ||
                       is_branch || is_jump || (OPcode == OP_LUI) || (OPcode == OP_AUIPC);

    assign state       = state_q;
    assign trap        = trap_q;
    assign bus_timeout = bto_q;

    // Datapath operand/immediate/ALU selects, decoded straight from the IR fields.
    always_comb begin
        ImmSel      = IMM_I;
        ALUSrc_B    = 1'b0;
        MemtoReg    = 2'b00;
        ALU_Control = ALU_ADD;
        case (OPcode)
            OP_R: ALU_Control = {Fun7, Fun3};
            OP_I: begin
                ALUSrc_B    = 1'b1;
                // Fun7 only selects SRA vs SRL; for other I-ops inst[30] is immediate data.
                ALU_Control = (Fun3 == 3'b101) ? {Fun7, Fun3} : {1'b0, Fun3};
            end
            OP_LOAD: begin
                ALUSrc_B = 1'b1;
                MemtoReg = 2'b01;
            end
            OP_STORE: begin
                ImmSel   = IMM_S;
                ALUSrc_B = 1'b1;
            end
            OP_BRANCH: begin
                ImmSel = IMM_B;
                case (Fun3[2:1])
                    2'b10:   ALU_Control = ALU_SLT;
                    2'b11:   ALU_Control = ALU_SLTU;
                    default: ALU_Control = ALU_SUB;
                endcase
            end
            OP_JAL: begin
                ImmSel   = IMM_J;
                MemtoReg = 2'b10;
            end
            OP_JALR: begin
                ALUSrc_B = 1'b1;
                MemtoReg = 2'b10;
            end
            OP_LUI: begin
                ImmSel   = IMM_U;
                ALUSrc_B = 1'b1;
                MemtoReg = 2'b11;
            end
            OP_AUIPC: begin
                ImmSel   = IMM_U;
                ALUSrc_B = 1'b1;
            end
            default: ;
        endcase
    end

    // Next-state, wait-timeout and strobe logic; strobes are held low during reset.
    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;
        trap_d   = trap_q;
        bto_d    = bto_q;
        wait_c   = 1'b0;
        Jump     = 1'b0;
        Branch   = 1'b0;
        RegWrite = 1'b0;
        MemRW    = 1'b0;
        CPU_MIO  = 1'b0;
        PCWrite  = 1'b0;
        IRWrite  = 1'b0;

        case (state_q)
            ST_FETCH: begin
                CPU_MIO = 1'b1;
                if (MIO_ready) begin
                    IRWrite = 1'b1;
                    state_d = ST_DECODE;
                end else begin
                    wait_c = 1'b1;
                end
            end
            ST_DECODE: state_d = is_legal ? ST_EXEC : ST_TRAP;
            ST_EXEC: begin
                if (is_branch) begin
                    Branch  = 1'b1;
                    PCWrite = 1'b1;
                    state_d = ST_FETCH;
                end else if (is_load || is_store) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                CPU_MIO = 1'b1;
                MemRW   = is_store;
                if (MIO_ready) begin
                    PCWrite = is_store;
                    state_d = is_store ? ST_FETCH : ST_WB;
                end else begin
                    wait_c = 1'b1;
                end
            end
            ST_WB: begin
                RegWrite = 1'b1;
                PCWrite  = 1'b1;
                Jump     = is_jump;
                state_d  = ST_FETCH;
            end
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_TRAP;
        endcase

        // A ready cycle never counts as a wait, so completion beats the timeout.
        if (wait_c) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
            if ((TIMEOUT_CYCLES != 0) && (cnt_d >= TIMEOUT_LIM)) begin
                state_d = ST_TRAP;
                bto_d   = 1'b1;
            end
        end

        if (state_d == ST_TRAP) begin
            trap_d = 1'b1;
        end

        if (!rst_n) begin
            Jump     = 1'b0;
            Branch   = 1'b0;
            RegWrite = 1'b0;
            MemRW    = 1'b0;
            CPU_MIO  = 1'b0;
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
        end
    end

    // State, timeout counter and sticky fault flags with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            cnt_q   <= '0;
            trap_q  <= 1'b0;
            bto_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            trap_q  <= trap_d;
            bto_q   <= bto_d;
        end
    end

endmodule

// File: doc/multicycle_cpu_control.md
# multicycle_cpu_control

Multi-cycle successor to the single-cycle `my_cpu_control` decoder for the RV32I lab CPU. Sequences each instruction through FETCH / DECODE / EXEC / MEM / WB states and drives the datapath strobes. Stalls on the `MIO_ready` memory handshake, with an optional wait timeout. Traps on illegal opcodes. Sits between the instruction register (`inst` fields) and the multi-cycle datapath/MIO bus.

## Interface
- `TIMEOUT_CYCLES`, default 0: max consecutive wait cycles with `MIO_ready`=0 in FETCH/MEM before trapping; 0 disables the timeout.
- `CNT_W`, default 8: timeout counter width; requires TIMEOUT_CYCLES < 2^CNT_W.

- `clk`  in  1  clock. One clock domain only; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `OPcode`  in  5  inst[6:2].
- `Fun3`  in  3  inst[14:12].
- `Fun7`  in  1  inst[30].
- `MIO_ready`  in  1  memory/IO transfer complete this cycle.
- `ImmSel`  out  3  000 I, 001 S, 010 B, 011 J, 100 U.
- `ALUSrc_B`  out  1  1 = immediate operand.
- `MemtoReg`  out  2  00 ALU, 01 memory, 10 PC+4, 11 immediate (LUI).
- `ALU_Control`  out  4  encodes {f7, f3}: ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111.
- `Jump`, `Branch`, `RegWrite`, `MemRW`, `CPU_MIO`, `PCWrite`, `IRWrite`  out  1 each  datapath strobes; `MemRW`=1 means write.
- `state`  out  3  FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4, TRAP 7.
- `trap`  out  1  sticky fault flag.
- `bus_timeout`  out  1  sticky; set when the trap cause is a timeout.

## Operation
- Decode outputs (ImmSel, ALUSrc_B, MemtoReg, ALU_Control) are combinational from OPcode/Fun3/Fun7 and valid from DECODE onward.
- ALU_Control:
  - R-type: {Fun7, Fun3}.
  - I-ALU: {Fun7, Fun3} when Fun3=101, otherwise {0, Fun3}.
  - LOAD, STORE, JALR, AUIPC: ADD.
  - BRANCH: SUB for f3=00x, SLT for 10x, SLTU for 11x.
- FETCH:
  - CPU_MIO=1, MemRW=0.
  - On MIO_ready=1: IRWrite=1, go to DECODE.
  - Otherwise hold in FETCH.
- DECODE:
  - Opcodes 01100, 00100, 00000, 01000, 11000, 11011, 11001, 01101, 00101 go to EXEC.
  - Any other opcode goes to TRAP.
- EXEC:
  - BRANCH: Branch=1, PCWrite=1, go to FETCH. Taken/not-taken is resolved in the datapath.
  - LOAD/STORE: go to MEM.
  - All other classes: go to WB.
- MEM:
  - CPU_MIO=1; MemRW=1 for STORE only.
  - On MIO_ready=1: LOAD goes to WB; STORE asserts PCWrite=1 and goes to FETCH.
- WB:
  - RegWrite=1, PCWrite=1, go to FETCH.
  - Jump=1 during WB for JAL/JALR, with MemtoReg=10.
- Timeout counter:
  - Increments each FETCH/MEM cycle with MIO_ready=0.
  - Clears on MIO_ready=1 and on every state change.
  - If TIMEOUT_CYCLES≠0 and the count reaches TIMEOUT_CYCLES, the next state is TRAP and bus_timeout is set. The counter saturates and never wraps.
- TRAP:
  - Absorbing state; exits only on reset.
  - All strobes are 0; trap=1.

## Timing
- Reset:
  - In any cycle sampled with rst_n=0, the next state is FETCH, and the counter, trap and bus_timeout clear.
  - Strobes are forced 0 combinationally while rst_n=0, including when reset is asserted mid-instruction (no partial RegWrite/MemRW).
- State register updates on the rising clk edge.
- Strobes are combinational from state and MIO_ready: IRWrite, and PCWrite in MEM, are asserted only in the cycle MIO_ready=1.
- Latency with zero-wait memory:
  - Branch: 3 cycles.
  - Store: 4 cycles.
  - R/I/JAL/JALR/LUI/AUIPC: 4 cycles.
  - Load: 5 cycles.
  - Each wait cycle adds 1.
- MIO_ready outside FETCH/MEM is ignored.
- If MIO_ready=1 arrives in the same cycle the counter would reach TIMEOUT_CYCLES, completion wins; no trap.

## Test plan
- Reset, then R-type ADD (0x00B50533, MIO_ready=1):
  - state sequence 0→1→2→4→0.
  - IRWrite in cycle 0; RegWrite=1 and PCWrite=1 in cycle 3.
  - ALU_Control=0000, MemtoReg=00.
- SUB (0x40B50533) → ALU_Control=1000. SRAI (0x40355513) → ALU_Control=1101, ALUSrc_B=1, ImmSel=000.
- LW (0x00052583) with MIO_ready low for 2 cycles in MEM:
  - MEM held 3 cycles with CPU_MIO=1, MemRW=0.
  - Then WB with MemtoReg=01; total 7 cycles.
- SW (0x00B52023): MEM state has MemRW=1, CPU_MIO=1, ImmSel=001; PCWrite in the completion cycle; no RegWrite.
- BLTU (0x00B56463): EXEC has Branch=1, PCWrite=1, ALU_Control=0011, ImmSel=010; 3 cycles total. JAL (0x008000EF): WB has Jump=1, MemtoReg=10, ImmSel=011.
- Traps:
  - Opcode 0x0000007F → TRAP from DECODE; trap=1, bus_timeout=0, all strobes 0 until rst_n=0.
  - TIMEOUT_CYCLES=4 with MIO_ready held 0 in FETCH → TRAP after 4 wait cycles, bus_timeout=1.
  - Reset asserted mid-MEM → next state FETCH, no MemRW pulse while rst_n=0.
